// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Purpose  : DLX MEM stage. Issues lane-aligned loads/stores, stalls on the
//            bus handshake with a timeout, formats load data and forwards the
//            ALU result to EX. Define MEM_MISALIGN_TRAP_EN to trap misaligned
//            accesses instead of aligning them down.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int WAIT_MAX = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_alu_out,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              ex_ld,
  input  logic              ex_st,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  output logic [XLEN-1:0]   d_address,
  output logic [XLEN-1:0]   d_data_write,
  output logic [XLEN/8-1:0] d_byte_en,
  output logic              d_write_enable,
  output logic              d_read_enable,
  input  logic [XLEN-1:0]   d_data_read,
  input  logic              d_data_valid,
  output logic              stall,
  output logic              fwd_valid,
  output logic [RA_W-1:0]   fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [RA_W-1:0]   wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              bus_err,
  output logic              misalign
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] c_wait_last = CW'(WAIT_MAX - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_wait_cnt;

  // Copy of the access held while waiting on the bus
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_sdata;
  logic [RA_W-1:0] r_rd;
  logic [1:0]      r_size;
  logic            r_uns;
  logic            r_ld;
  logic            r_st;

  logic            w_in_wait;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_sdata;
  logic [RA_W-1:0] w_rd;
  logic [1:0]      w_size;
  logic            w_uns;
  logic            w_ld;
  logic            w_st;

  logic [1:0]      w_eff_size;
  logic [3:0]      w_nbytes;
  logic [6:0]      w_nbits;
  logic [OW-1:0]   w_low_mask;
  logic [OW-1:0]   w_off;
  logic [XLEN-1:0] w_addr;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_fmt;
  logic            w_sign;

  logic            w_mem_req;
  logic            w_trap;
  logic            w_access;
  logic            w_timeout;
  logic            w_fault;
  logic            w_wb_valid;

  assign w_in_wait = (r_state == S_WAIT);

  always_comb begin
    w_alu   = ex_alu_out;
    w_sdata = ex_store_data;
    w_rd    = ex_rd;
    w_size  = ex_size;
    w_uns   = ex_unsigned;
    w_ld    = ex_ld;
    w_st    = ex_st;
    if (w_in_wait) begin
      w_alu   = r_alu;
      w_sdata = r_sdata;
      w_rd    = r_rd;
      w_size  = r_size;
      w_uns   = r_uns;
      w_ld    = r_ld;
      w_st    = r_st;
    end
  end

  // A dword request on a 32-bit datapath collapses to a full-width word
  assign w_eff_size = (w_size > 2'(OW)) ? 2'(OW) : w_size;
  assign w_nbytes   = 4'd1 << w_eff_size;
  assign w_nbits    = {w_nbytes, 3'b000};
  assign w_low_mask = w_nbytes[OW-1:0] - OW'(1);
  assign w_off      = w_alu[OW-1:0] & ~w_low_mask;
  assign w_addr     = {w_alu[XLEN-1:OW], w_off};

  always_comb begin
    w_be = '0;
    for (int i = 0; i < NB; i++) begin
      w_be[i] = (i >= int'(w_off)) && (i < int'(w_off) + int'(w_nbytes));
    end
  end

  assign w_shifted = d_data_read >> {w_off, 3'b000};

  always_comb begin
    w_sign = 1'b0;
    w_fmt  = '0;
    for (int b = 0; b < XLEN; b++) begin
      if (b == int'(w_nbits) - 1) w_sign = w_shifted[b];
    end
    for (int b = 0; b < XLEN; b++) begin
      w_fmt[b] = (b < int'(w_nbits)) ? w_shifted[b] : (w_sign & ~w_uns);
    end
  end

  assign w_mem_req = w_in_wait | (ex_valid & (ex_ld | ex_st));

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misal;
  logic r_misalign;

  assign w_misal  = |(w_alu[OW-1:0] & w_low_mask);
  assign w_trap   = ~w_in_wait & ex_valid & (ex_ld | ex_st) & w_misal;
  assign misalign = r_misalign;

  always_ff @(posedge clk) begin
    if (!reset_n) r_misalign <= 1'b0;
    else          r_misalign <= w_trap;
  end
`else
  assign w_trap   = 1'b0;
  assign misalign = 1'b0;
`endif

  assign w_access = w_mem_req & ~w_trap;
  assign w_fault  = w_timeout | w_trap;

  assign d_address      = w_addr;
  assign d_data_write   = w_sdata << {w_off, 3'b000};
  assign d_byte_en      = w_access ? w_be : '0;
  assign d_read_enable  = w_access & w_ld;
  assign d_write_enable = w_access & w_st;

  assign fwd_valid = ex_valid & ~ex_ld & (ex_rd != '0);
  assign fwd_rd    = ex_rd;
  assign fwd_data  = ex_alu_out;

  // A timeout retires the instruction as faulted, so the pipeline is released
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    stall        = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_access & ~d_data_valid;
        if (w_access && !d_data_valid) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_timeout = ~d_data_valid & (r_wait_cnt == c_wait_last);
        stall     = ~d_data_valid & ~w_timeout;
        if (d_data_valid || w_timeout) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= (w_in_wait && w_state_next == S_WAIT) ? r_wait_cnt + CW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_in_wait) begin
      r_alu   <= ex_alu_out;
      r_sdata <= ex_store_data;
      r_rd    <= ex_rd;
      r_size  <= ex_size;
      r_uns   <= ex_unsigned;
      r_ld    <= ex_ld;
      r_st    <= ex_st;
    end
  end

  assign w_wb_valid = w_in_wait | ex_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= w_timeout;
      if (!stall) begin
        wb_valid <= w_wb_valid;
        wb_we    <= w_wb_valid & (w_rd != '0) & ~w_st & ~w_fault;
        wb_rd    <= w_rd;
        wb_data  <= (w_ld & ~w_fault) ? w_fmt : w_alu;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Purpose  : Self-checking bench for mem_stage_lsu: transaction-level model
//            with randomized instructions and bus latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

  localparam int XLEN     = 32;
  localparam int RA_W     = 5;
  localparam int WAIT_MAX = 16;

  logic              clk;
  logic              reset_n;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_alu_out;
  logic [XLEN-1:0]   ex_store_data;
  logic [RA_W-1:0]   ex_rd;
  logic              ex_ld;
  logic              ex_st;
  logic [1:0]        ex_size;
  logic              ex_unsigned;
  logic [XLEN-1:0]   d_address;
  logic [XLEN-1:0]   d_data_write;
  logic [3:0]        d_byte_en;
  logic              d_write_enable;
  logic              d_read_enable;
  logic [XLEN-1:0]   d_data_read;
  logic              d_data_valid;
  logic              stall;
  logic              fwd_valid;
  logic [RA_W-1:0]   fwd_rd;
  logic [XLEN-1:0]   fwd_data;
  logic              wb_valid;
  logic              wb_we;
  logic [RA_W-1:0]   wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              bus_err;
  logic              misalign;

  mem_stage_lsu #(.XLEN(XLEN), .RA_W(RA_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_ld(ex_ld), .ex_st(ex_st),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .d_address(d_address),
    .d_data_write(d_data_write), .d_byte_en(d_byte_en), .d_write_enable(d_write_enable),
    .d_read_enable(d_read_enable), .d_data_read(d_data_read), .d_data_valid(d_data_valid),
    .stall(stall), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .bus_err(bus_err), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Expected outputs for the current cycle
  bit          exp_stall, exp_rd_en, exp_wr_en, exp_fwd_valid;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata, exp_fwd_data;
  logic [4:0]  exp_fwd_rd;
  bit          exp_wb_valid, exp_wb_we, exp_bus_err, exp_misalign;
  logic [4:0]  exp_wb_rd;
  logic [31:0] exp_wb_data;

  // Effects that land at the next clock edge
  bit          pend_wb, pend_wb_valid, pend_wb_we, pend_bus_err, pend_mis;
  logic [4:0]  pend_wb_rd;
  logic [31:0] pend_wb_data;

  // Snapshot of the first cycle of the latest instruction
  logic [3:0]  cap_be;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_rd_en;
  int          cap_stall_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",    64'(stall),          64'(exp_stall));
      check("rd_en",    64'(d_read_enable),  64'(exp_rd_en));
      check("wr_en",    64'(d_write_enable), 64'(exp_wr_en));
      check("byte_en",  64'(d_byte_en),      64'(exp_be));
      if (exp_rd_en || exp_wr_en) check("address", 64'(d_address), 64'(exp_addr));
      if (exp_wr_en) check("wdata", 64'(d_data_write), 64'(exp_wdata));
      check("fwd_valid", 64'(fwd_valid), 64'(exp_fwd_valid));
      check("fwd_rd",    64'(fwd_rd),    64'(exp_fwd_rd));
      check("fwd_data",  64'(fwd_data),  64'(exp_fwd_data));
      check("wb_valid",  64'(wb_valid),  64'(exp_wb_valid));
      check("wb_we",     64'(wb_we),     64'(exp_wb_we));
      if (exp_wb_valid) begin
        check("wb_rd",   64'(wb_rd),   64'(exp_wb_rd));
        check("wb_data", 64'(wb_data), 64'(exp_wb_data));
      end
      check("bus_err",  64'(bus_err),  64'(exp_bus_err));
      check("misalign", 64'(misalign), 64'(exp_misalign));
    end
  end

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] be_of(input int off, input int nb);
    int m;
    m = ((1 << nb) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] fmt_of(input logic [31:0] rdata, input int off,
                                         input int nb, input bit uns);
    longint unsigned v, mask;
    v    = 64'(rdata) >> (8 * off);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = v & mask;
    if (!uns && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (pend_wb) begin
      exp_wb_valid = pend_wb_valid;
      exp_wb_we    = pend_wb_we;
      exp_wb_rd    = pend_wb_rd;
      exp_wb_data  = pend_wb_data;
    end
    exp_bus_err  = pend_bus_err;
    exp_misalign = pend_mis;
  endtask

  // One instruction held in MEM until it leaves; lat = cycles until d_data_valid
  task automatic do_instr(input bit v, input bit ld, input bit st, input logic [1:0] sz,
                          input bit uns, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input int lat, input logic [31:0] rdata,
                          input int rst_at);
    int nb, off;
    logic [31:0] al;
    bit mem, trap, issue, done, tmo, stalled;
    nb    = nbytes_of(sz);
    al    = addr - (addr % nb);
    off   = int'(al % 4);
    mem   = v && (ld || st);
    trap  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap  = mem && ((addr % nb) != 0);
`endif
    issue = mem && !trap;
    cap_stall_cnt = 0;
    for (int k = 0; k <= WAIT_MAX + 2; k++) begin
      if (k == rst_at) begin
        chk_en = 1'b0;
        pend_wb = 1'b0; pend_bus_err = 1'b0; pend_mis = 1'b0;
        reset_n = 1'b0; ex_valid = 1'b0; d_data_valid = 1'b0;
        step();
        reset_n = 1'b1;
        exp_wb_valid = 1'b0; exp_wb_we = 1'b0; exp_wb_rd = '0; exp_wb_data = '0;
        exp_bus_err = 1'b0; exp_misalign = 1'b0;
        exp_stall = 1'b0; exp_rd_en = 1'b0; exp_wr_en = 1'b0; exp_be = '0;
        chk_en = 1'b1;
        return;
      end
      ex_valid = v; ex_ld = ld; ex_st = st; ex_size = sz; ex_unsigned = uns;
      ex_alu_out = addr; ex_store_data = sdata; ex_rd = rd;
      d_data_valid = (k == lat) ? 1'b1 : (!issue && $urandom_range(0, 3) == 0);
      d_data_read  = (k == lat) ? rdata : $urandom;
      done = issue && (k == lat);
      tmo  = issue && (k == WAIT_MAX) && (lat > WAIT_MAX);
      stalled       = issue && !done && !tmo;
      exp_stall     = stalled;
      exp_rd_en     = issue && ld;
      exp_wr_en     = issue && st;
      exp_be        = issue ? be_of(off, nb) : 4'h0;
      exp_addr      = al;
      exp_wdata     = sdata << (8 * off);
      exp_fwd_valid = v && !ld && (rd != 0);
      exp_fwd_rd    = rd;
      exp_fwd_data  = addr;
      #1;
      if (k == 0) begin
        cap_be = d_byte_en; cap_addr = d_address; cap_wdata = d_data_write;
        cap_rd_en = d_read_enable;
      end
      if (stall === 1'b1) cap_stall_cnt++;
      pend_bus_err = tmo;
      pend_mis     = trap;
      pend_wb      = !stalled;
      if (!stalled) begin
        pend_wb_valid = v;
        pend_wb_we    = v && (rd != 0) && !st && !tmo && !trap;
        pend_wb_rd    = rd;
        pend_wb_data  = (ld && done) ? fmt_of(rdata, off, nb, uns) : addr;
      end
      step();
      if (!stalled) break;
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; ex_valid = 1'b0; ex_ld = 1'b0; ex_st = 1'b0; ex_size = 2'd0;
    ex_unsigned = 1'b0; ex_alu_out = '0; ex_store_data = '0; ex_rd = '0;
    d_data_valid = 1'b0; d_data_read = '0;
    pend_wb = 1'b0; pend_bus_err = 1'b0; pend_mis = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wb_valid", 64'(wb_valid), 64'd0);
    check("reset_wb_we",    64'(wb_we),    64'd0);
    check("reset_wb_rd",    64'(wb_rd),    64'd0);
    check("reset_wb_data",  64'(wb_data),  64'd0);
    check("reset_bus_err",  64'(bus_err),  64'd0);
    check("reset_misalign", 64'(misalign), 64'd0);
    check("reset_stall",    64'(stall),    64'd0);
    reset_n = 1'b1;
    exp_wb_valid = 1'b0; exp_wb_we = 1'b0; exp_wb_rd = '0; exp_wb_data = '0;
    exp_bus_err = 1'b0; exp_misalign = 1'b0;
    chk_en = 1'b1;

    // SW 0x100, zero-wait
    do_instr(1, 0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 5'd3, 0, 32'h0, -1);
    check("sw_be",     64'(cap_be),        64'hF);
    check("sw_wdata",  64'(cap_wdata),     64'hDEADBEEF);
    check("sw_stalls", 64'(cap_stall_cnt), 64'd0);
    check("sw_wb_we",  64'(wb_we),         64'd0);

    // LB / LBU 0x103, valid after 3 cycles
    do_instr(1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 5'd4, 3, 32'h80123456, -1);
    check("lb_stalls", 64'(cap_stall_cnt), 64'd3);
    check("lb_data",   64'(wb_data),       64'hFFFFFF80);
    check("lb_we",     64'(wb_we),         64'd1);
    do_instr(1, 1, 0, 2'd0, 1, 32'h103, 32'h0, 5'd4, 3, 32'h80123456, -1);
    check("lbu_data",  64'(wb_data),       64'h00000080);

    // SH 0x202
    do_instr(1, 0, 1, 2'd1, 0, 32'h202, 32'h1234, 5'd0, 0, 32'h0, -1);
    check("sh_be",    64'(cap_be),    64'hC);
    check("sh_wdata", 64'(cap_wdata), 64'h12340000);

    // LW timeout, then completion on the timeout cycle
    do_instr(1, 1, 0, 2'd2, 0, 32'h300, 32'h0, 5'd5, 100, 32'h0, -1);
    check("to_stalls",  64'(cap_stall_cnt), 64'd16);
    check("to_bus_err", 64'(bus_err),       64'd1);
    check("to_wb_valid", 64'(wb_valid),     64'd1);
    check("to_wb_we",   64'(wb_we),         64'd0);
    do_instr(1, 1, 0, 2'd2, 0, 32'h300, 32'h0, 5'd5, WAIT_MAX, 32'hCAFEF00D, -1);
    check("late_bus_err", 64'(bus_err), 64'd0);
    check("late_wb_we",   64'(wb_we),   64'd1);
    check("late_data",    64'(wb_data), 64'hCAFEF00D);

    // LW 0x101
    do_instr(1, 1, 0, 2'd2, 0, 32'h101, 32'h0, 5'd6, 0, 32'h11223344, -1);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_rd_en", 64'(cap_rd_en), 64'd0);
    check("mis_pulse", 64'(misalign),  64'd1);
    check("mis_wb_we", 64'(wb_we),     64'd0);
`else
    check("al_addr",   64'(cap_addr),  64'h100);
    check("al_data",   64'(wb_data),   64'h11223344);
`endif

    // Reset during WAIT abandons the access
    do_instr(1, 1, 0, 2'd2, 0, 32'h400, 32'h0, 5'd7, 100, 32'h0, 4);
    #1;
    check("rstwait_stall",    64'(stall),    64'd0);
    check("rstwait_wb_valid", 64'(wb_valid), 64'd0);
    check("rstwait_wb_we",    64'(wb_we),    64'd0);

    for (int n = 0; n < 400; n++) begin
      bit v, ld, st, uns;
      logic [1:0] sz;
      logic [4:0] rd;
      int r, lat;
      v   = ($urandom_range(0, 9) != 0);
      r   = $urandom_range(0, 2);
      ld  = (r == 0);
      st  = (r == 1);
      uns = $urandom_range(0, 1) == 1;
      sz  = 2'($urandom_range(0, 2));
      rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r   = $urandom_range(0, 19);
      lat = (r < 9) ? 0 : (r < 17) ? $urandom_range(1, 5) :
            (r == 17) ? WAIT_MAX : WAIT_MAX + 1 + $urandom_range(0, 3);
      do_instr(v, ld, st, sz, uns, $urandom, $urandom, rd, lat, $urandom, -1);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
